// File: rtl/sisc_pkg.sv
// sisc_pkg: shared fetch-stage types and constants for the SISC core.
package sisc_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, HOLD = 2'b10} fetch_state_e;
    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam int unsigned ADDR_W_DEF = 16;
endpackage

// File: rtl/sisc_pc.sv
// sisc_pc: program counter with branch load, wrapping increment and reset-to-RESET_PC.
module sisc_pc
    import sisc_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] tgt_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_nxt_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb pc_d = load_i ? tgt_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;

    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) pc_q <= ADDR_W'(RESET_PC);
        else pc_q <= pc_d;

    assign pc_o     = pc_q;
    assign pc_nxt_o = pc_d;
endmodule

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction-fetch stage with req/ack memory handshake and branch redirect.
// Optional fetch timeout enabled by defining SISC_FETCH_TIMEOUT_EN.
module sisc_fetch
    import sisc_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_f,
    output logic              im_req,
    output logic [ADDR_W-1:0] im_addr,
    input  logic              im_ack,
    input  logic [31:0]       im_data,
    output logic [31:0]       ir,
    output logic              ir_valid,
    input  logic              ir_take,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_tgt,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);
    fetch_state_e      state_q;
    logic              im_req_q, ir_valid_q;
    logic [ADDR_W-1:0] im_addr_q, pc_nxt;
    logic [31:0]       ir_q;
    logic              ack_ok, tmo, take_ok;

    assign ack_ok  = state_q == REQ && im_ack;
    assign take_ok = state_q == HOLD && ir_take;

`ifdef SISC_FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;

    // Counter sits at zero outside REQ, so every REQ entry starts from a clean count.
    assign tmo = state_q == REQ && !im_ack && cnt_q == CW'(TIMEOUT - 1);

    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (state_q == REQ && !im_ack && !tmo) ? cnt_q + CW'(1) : '0;
            err_q <= err_q | tmo;
        end

    assign fetch_err = err_q;
`else
    assign tmo       = 1'b0;
    assign fetch_err = 1'b0;
`endif

    sisc_pc #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk     (clk),
        .rst_f   (rst_f),
        .inc_i   (ack_ok | tmo),
        .load_i  (take_ok & br_taken),
        .tgt_i   (br_tgt),
        .pc_o    (pc_out),
        .pc_nxt_o(pc_nxt)
    );

    // A timeout completes the fetch exactly like an ack, but with a NOP word.
    always_ff @(posedge clk or negedge rst_f)
        if (!rst_f) begin
            state_q    <= IDLE;
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
            im_req_q   <= 1'b0;
            im_addr_q  <= '0;
        end else
            case (state_q)
                IDLE: begin
                    state_q   <= REQ;
                    im_req_q  <= 1'b1;
                    im_addr_q <= pc_nxt;
                end
                REQ:
                    if (ack_ok || tmo) begin
                        state_q    <= HOLD;
                        ir_q       <= ack_ok ? im_data : NOP;
                        ir_valid_q <= 1'b1;
                        im_req_q   <= 1'b0;
                    end
                HOLD:
                    if (ir_take) begin
                        state_q    <= REQ;
                        ir_valid_q <= 1'b0;
                        im_req_q   <= 1'b1;
                        im_addr_q  <= pc_nxt;
                    end
                default: state_q <= IDLE;
            endcase

    assign im_req   = im_req_q;
    assign im_addr  = im_addr_q;
    assign ir       = ir_q;
    assign ir_valid = ir_valid_q;
endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: directed plus randomized transaction-level checks of sisc_fetch.
module tb_sisc_fetch;
    localparam int AW = 16;

    logic          clk = 1'b0, rst_f = 1'b0;
    logic          im_ack = 1'b0, ir_take = 1'b0, br_taken = 1'b0;
    logic [31:0]   im_data = '0;
    logic [AW-1:0] br_tgt = '0;
    logic          im_req, ir_valid, fetch_err;
    logic [AW-1:0] im_addr, pc_out;
    logic [31:0]   ir;

    logic          w_req, w_valid, w_err;
    logic [3:0]    w_addr, w_pc;
    logic [31:0]   w_ir;

    int tests = 0, fails = 0;
    logic [AW-1:0] m_pc = '0;
    logic [31:0]   m_ir = '0;
    logic          m_err = 1'b0;

    sisc_fetch #(.ADDR_W(AW)) dut (
        .clk(clk), .rst_f(rst_f), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
        .im_data(im_data), .ir(ir), .ir_valid(ir_valid), .ir_take(ir_take),
        .br_taken(br_taken), .br_tgt(br_tgt), .pc_out(pc_out), .fetch_err(fetch_err)
    );

    // Narrow PC instance: always acking and taking, starting at the top address.
    sisc_fetch #(.ADDR_W(4), .RESET_PC(15)) dut_w4 (
        .clk(clk), .rst_f(rst_f), .im_req(w_req), .im_addr(w_addr), .im_ack(1'b1),
        .im_data(32'hA5A5_0000), .ir(w_ir), .ir_valid(w_valid), .ir_take(1'b1),
        .br_taken(1'b0), .br_tgt(4'h0), .pc_out(w_pc), .fetch_err(w_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in REQ; waits `delay` cycles with noise, then acks `data`.
    task automatic fetch(input int delay, input logic [31:0] data);
        chk("req_start", im_req, 1'b1);
        chk("addr_start", im_addr, m_pc);
        for (int i = 0; i < delay; i++) begin
            im_ack   = 1'b0;
            ir_take  = 1'($urandom);
            br_taken = 1'($urandom);
            br_tgt   = AW'($urandom);
            tick();
            chk("req_wait", im_req, 1'b1);
            chk("addr_wait", im_addr, m_pc);
            chk("ir_wait", ir, m_ir);
            chk("valid_wait", ir_valid, 1'b0);
        end
        ir_take  = 1'b0;
        br_taken = 1'b0;
        im_ack   = 1'b1;
        im_data  = data;
        tick();
        im_ack = 1'b0;
        m_ir   = data;
        m_pc   = m_pc + 1'b1;
        chk("ir_ack", ir, m_ir);
        chk("valid_ack", ir_valid, 1'b1);
        chk("req_ack", im_req, 1'b0);
        chk("pc_ack", pc_out, m_pc);
        chk("err_ack", fetch_err, m_err);
    endtask

    // Entered in HOLD; holds for `h` cycles with noise, then takes with optional branch.
    task automatic hold_take(input int h, input logic br, input logic [AW-1:0] tgt);
        for (int i = 0; i < h; i++) begin
            ir_take  = 1'b0;
            br_taken = 1'($urandom);
            br_tgt   = AW'($urandom);
            im_ack   = 1'($urandom);
            im_data  = $urandom;
            tick();
            chk("ir_hold", ir, m_ir);
            chk("valid_hold", ir_valid, 1'b1);
            chk("req_hold", im_req, 1'b0);
            chk("pc_hold", pc_out, m_pc);
        end
        im_ack   = 1'b0;
        ir_take  = 1'b1;
        br_taken = br;
        br_tgt   = tgt;
        tick();
        ir_take  = 1'b0;
        br_taken = 1'b0;
        if (br) m_pc = tgt;
        chk("valid_take", ir_valid, 1'b0);
        chk("req_take", im_req, 1'b1);
        chk("addr_take", im_addr, m_pc);
        chk("pc_take", pc_out, m_pc);
        chk("ir_take", ir, m_ir);
    endtask

    initial begin
        #12;
        chk("rst_req", im_req, 1'b0);
        chk("rst_addr", im_addr, 0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_valid", ir_valid, 1'b0);
        chk("rst_pc", pc_out, 0);
        chk("rst_err", fetch_err, 1'b0);
        chk("w4_rst_pc", w_pc, 4'hF);
        @(posedge clk);
        #1;
        rst_f   = 1'b1;
        im_ack  = 1'b1;
        im_data = 32'hDEAD_BEEF;
        tick();
        im_ack = 1'b0;
        chk("idle_ack_ignored", ir_valid, 1'b0);
        chk("idle_ir", ir, 32'h0);
        chk("w4_addr15", w_addr, 4'hF);
        fetch(0, 32'h1111_0001);
        chk("w4_wrap_pc", w_pc, 4'h0);
        tick();
        chk("w4_wrap_addr", w_addr, 4'h0);
        chk("w4_wrap_req", w_req, 1'b1);
        chk("ir_hold0", ir, 32'h1111_0001);
        chk("req_hold0", im_req, 1'b0);
        hold_take(4, 1'b0, '0);
        chk("addr_after_take", im_addr, 1);
        fetch(2, $urandom);
        hold_take(1, 1'b1, 16'h0040);
        fetch(0, $urandom);
        chk("pc_after_branch", pc_out, 16'h0041);
        hold_take(0, 1'b1, 16'hFFFF);
        fetch(1, $urandom);
        chk("pc_wrap16", pc_out, 0);
        hold_take(2, 1'b1, m_pc);
        fetch(0, $urandom);
        hold_take(0, 1'b0, '0);
        repeat (20) begin
            fetch($urandom_range(0, 4), $urandom);
            hold_take($urandom_range(0, 3), 1'($urandom), AW'($urandom));
        end
        fetch(3, 32'hCAFE_0003);
        hold_take(1, 1'b0, '0);
        tick();
        tick();
        #2;
        rst_f = 1'b0;
        #1;
        chk("async_req", im_req, 1'b0);
        chk("async_addr", im_addr, 0);
        chk("async_ir", ir, 32'h0);
        chk("async_valid", ir_valid, 1'b0);
        chk("async_pc", pc_out, 0);
        im_ack  = 1'b1;
        im_data = 32'h7777_7777;
        tick();
        chk("late_ack_ir", ir, 32'h0);
        chk("late_ack_valid", ir_valid, 1'b0);
        rst_f = 1'b1;
        tick();
        im_ack = 1'b0;
        m_pc = '0;
        m_ir = '0;
        chk("refetch_valid", ir_valid, 1'b0);
        chk("refetch_ir", ir, 32'h0);
        fetch(1, $urandom);
        hold_take(0, 1'b0, '0);
`ifdef SISC_FETCH_TIMEOUT_EN
        fetch(14, 32'h0BAD_F00D);
        chk("ack15_no_err", fetch_err, 1'b0);
        hold_take(0, 1'b0, '0);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("tmo_wait_req", im_req, 1'b1);
            chk("tmo_wait_err", fetch_err, 1'b0);
        end
        tick();
        m_pc  = m_pc + 1'b1;
        m_ir  = 32'h0;
        m_err = 1'b1;
        chk("tmo_ir", ir, 32'h0);
        chk("tmo_valid", ir_valid, 1'b1);
        chk("tmo_err", fetch_err, 1'b1);
        chk("tmo_pc", pc_out, m_pc);
        hold_take(1, 1'b0, '0);
        fetch(0, $urandom);
        chk("err_sticky", fetch_err, 1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
